// File: rtl/systolic_ctrl.sv
// Sequencing controller for the MAC systolic array: clears the accumulators,
// streams K skewed operand pairs, flushes the pipeline with zeros, then pulses done.
module systolic_ctrl #(
  parameter int ARR_SIZE      = 4,
  parameter int HORIZONTAL_BW = 16,
  parameter int K_W           = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [K_W-1:0]                    k_len,
  output logic                              busy,
  output logic                              done,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] a_vec,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] b_vec,
  output logic                              mac_rst,
  output logic                              i_mode,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] vertical_input
);

  localparam int HBW  = HORIZONTAL_BW;
  localparam int FL_W = $clog2(2 * ARR_SIZE);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(2 * ARR_SIZE - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [K_W-1:0]  k_len_q;
  logic [K_W-1:0]  k_cnt_q;
  logic [FL_W-1:0] fl_cnt_q;

  logic accept;
  logic shift_en;
  logic clear_en;

  assign accept   = in_valid && (state_q == S_FEED);
  assign shift_en = (state_q == S_FEED) || (state_q == S_FLUSH);
  assign clear_en = (state_q == S_CLEAR);

  // Control outputs decode straight from the state register, so they carry
  // no combinational path from any input and fall to 0 with the async reset.
  assign mac_rst  = (state_q == S_CLEAR);
  assign in_ready = (state_q == S_FEED);
  assign i_mode   = shift_en;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      fl_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (k_len != '0)) begin
            k_len_q <= k_len;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          k_cnt_q  <= '0;
          fl_cnt_q <= '0;
          state_q  <= S_FEED;
        end
        S_FEED: begin
          if (accept) begin
            k_cnt_q <= k_cnt_q + K_W'(1);
            if (k_cnt_q == k_len_q - K_W'(1)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          fl_cnt_q <= fl_cnt_q + FL_W'(1);
          if (fl_cnt_q == FL_LAST) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Lane gi is a (gi+1)-deep shift register so element gi of a pair reaches
  // the array gi cycles after element 0, giving the diagonal wavefront.
  generate
    for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
      logic [HBW-1:0] a_sr_q [0:gi];
      logic [HBW-1:0] b_sr_q [0:gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j <= gi; j++) begin
            a_sr_q[j] <= '0;
            b_sr_q[j] <= '0;
          end
        end else if (clear_en) begin
          for (int j = 0; j <= gi; j++) begin
            a_sr_q[j] <= '0;
            b_sr_q[j] <= '0;
          end
        end else if (shift_en) begin
          a_sr_q[0] <= accept ? a_vec[HBW*gi +: HBW] : '0;
          b_sr_q[0] <= accept ? b_vec[HBW*gi +: HBW] : '0;
          for (int j = 1; j <= gi; j++) begin
            a_sr_q[j] <= a_sr_q[j-1];
            b_sr_q[j] <= b_sr_q[j-1];
          end
        end
      end

      assign horizontal_input[HBW*gi +: HBW] = a_sr_q[gi];
      assign vertical_input[HBW*gi +: HBW]   = b_sr_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl: a timeline model predicts every output
// from the accept edges (lane i after edge t carries the pair accepted at t-i).
module tb_systolic_ctrl;
  localparam int N   = 4;
  localparam int HBW = 16;
  localparam int KW  = 8;
  localparam int VW  = N * HBW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, in_ready, mac_rst, i_mode;
  logic          in_valid = 1'b0;
  logic [VW-1:0] a_vec = '0, b_vec = '0;
  logic [VW-1:0] horizontal_input, vertical_input;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [VW-1:0] sb_a [int];
  logic [VW-1:0] sb_b [int];

  systolic_ctrl #(.ARR_SIZE(N), .HORIZONTAL_BW(HBW), .K_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .mac_rst(mac_rst), .i_mode(i_mode),
    .horizontal_input(horizontal_input), .vertical_input(vertical_input)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*HBW +: HBW] = HBW'($urandom);
    return v;
  endfunction

  // Expected skewed bus after edge t, from the recorded accept history.
  function automatic logic [VW-1:0] skew_exp(input int t, input bit side_b);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (side_b) begin
        if (sb_b.exists(t - i)) r[i*HBW +: HBW] = sb_b[t - i][i*HBW +: HBW];
      end else begin
        if (sb_a.exists(t - i)) r[i*HBW +: HBW] = sb_a[t - i][i*HBW +: HBW];
      end
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, done, in_ready, mac_rst, i_mode} !== 5'b0 ||
        horizontal_input !== '0 || vertical_input !== '0) begin
      errors++;
      $display("FAIL %s ctrl=%b h=%h v=%h required all 0", tag,
               {busy, done, in_ready, mac_rst, i_mode}, horizontal_input, vertical_input);
    end
  endtask

  // Runs one job of k pairs. gap1: cycles with in_valid low after the first
  // accept. rnd_valid: random in_valid. fixed_vec: a lane i=i+1, b lane i=i+5.
  // noise: toggle start/k_len while busy (must be ignored).
  task automatic run_job(input int k, input int gap1, input bit rnd_valid,
                         input bit fixed_vec, input bit noise, input string tag);
    int e0, t, acc, done_edge, gap_left, limit;
    bit exp_mrst, exp_rdy, exp_imode, exp_done, exp_busy;
    logic [VW-1:0] eh, ev;
    sb_a.delete();
    sb_b.delete();
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    in_valid = 1'($urandom);
    e0 = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; done_edge = -1; gap_left = 0;
    limit = e0 + 8 * k + 64;
    forever begin
      t = edge_n;
      exp_mrst  = (t == e0);
      exp_rdy   = (t > e0) && (acc < k);
      exp_imode = (t > e0) && (done_edge < 0 || t < done_edge);
      exp_done  = (t == done_edge);
      exp_busy  = (done_edge < 0) || (t <= done_edge);
      eh = skew_exp(t, 1'b0);
      ev = skew_exp(t, 1'b1);
      checks += 7;
      if (mac_rst !== exp_mrst) begin errors++; $display("FAIL %s mac_rst e%0d got %b exp %b", tag, t - e0, mac_rst, exp_mrst); end
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL %s in_ready e%0d got %b exp %b", tag, t - e0, in_ready, exp_rdy); end
      if (i_mode !== exp_imode) begin errors++; $display("FAIL %s i_mode e%0d got %b exp %b", tag, t - e0, i_mode, exp_imode); end
      if (done !== exp_done) begin errors++; $display("FAIL %s done e%0d got %b exp %b", tag, t - e0, done, exp_done); end
      if (busy !== exp_busy) begin errors++; $display("FAIL %s busy e%0d got %b exp %b", tag, t - e0, busy, exp_busy); end
      if (horizontal_input !== eh) begin errors++; $display("FAIL %s horizontal e%0d got %h exp %h", tag, t - e0, horizontal_input, eh); end
      if (vertical_input !== ev) begin errors++; $display("FAIL %s vertical e%0d got %h exp %h", tag, t - e0, vertical_input, ev); end
      if (done_edge >= 0 && t > done_edge) break;
      if (t > limit) begin
        checks++; errors++;
        $display("FAIL %s timeout accepts got %0d exp %0d", tag, acc, k);
        break;
      end
      if (fixed_vec) begin
        for (int i = 0; i < N; i++) begin
          a_vec[i*HBW +: HBW] = HBW'(i + 1);
          b_vec[i*HBW +: HBW] = HBW'(i + 5);
        end
      end else begin
        a_vec = rand_vec();
        b_vec = rand_vec();
      end
      in_valid = rnd_valid ? ($urandom_range(2) != 0) : 1'b1;
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end
      if (noise) begin
        start = 1'($urandom);
        k_len = KW'($urandom);
      end
      if (exp_rdy && in_valid) begin
        sb_a[t + 1] = a_vec;
        sb_b[t + 1] = b_vec;
        acc++;
        if (acc == 1) gap_left = gap1;
        if (acc == k) done_edge = t + 1 + 2 * N - 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    $display("job %s K=%0d start_to_done=%0d", tag, k, done_edge - e0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'($urandom); k_len = KW'($urandom); in_valid = 1'($urandom);
      a_vec = rand_vec(); b_vec = rand_vec();
      #1 check_all_zero("reset_held");
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_single();
    run_job(1, 0, 1'b0, 1'b1, 1'b0, "single");
  endtask

  task automatic test_back_to_back();
    run_job(4, 0, 1'b0, 1'b0, 1'b1, "b2b_first");
    run_job(4, 0, 1'b0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_bubbles();
    run_job(3, 2, 1'b0, 1'b0, 1'b0, "bubbles");
  endtask

  task automatic test_k_zero();
    @(negedge clk);
    start = 1'b1; k_len = '0; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all_zero("k_zero_e0");
    @(negedge clk);
    check_all_zero("k_zero_e1");
    in_valid = 1'b0;
  endtask

  task automatic test_k_max();
    run_job(255, 0, 1'b0, 1'b0, 1'b0, "k_max");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(12, 1), 0, 1'b1, 1'b0, 1'b1, "random");
  endtask

  task automatic test_mid_reset();
    int n;
    @(negedge clk);
    start = 1'b1; k_len = 8'd3; in_valid = 1'b1;
    a_vec = rand_vec(); b_vec = rand_vec();
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && i_mode && !in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL mid_reset reach_flush got timeout exp FLUSH within 20 cycles");
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("mid_reset_async");
    @(negedge clk);
    check_all_zero("mid_reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset_released");
    run_job(1, 0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_k_zero();
    test_k_max();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
